tick_period_meter: RTL and testbench
====================================

Name: tick_period_meter

Overview:
- Measures the period and high time of a slow, asynchronous tick or clock signal, such as a divided 1 Hz output, in cycles of the 100 MHz system clock.
- It is the receiving end of the divided-clock interface: the divider produces the slow clock, and this block consumes it and checks it.
- It publishes one period/high-time pair per full input cycle, with a one-cycle valid strobe and a timeout flag for a stalled input.

Parameters:
- CNT_W, 32: width of the period and high-time counters and outputs.
- SYNC_STAGES, 2: number of synchroniser flops on sig_in; must be at least 2.
- TIMEOUT, 200000000: cycles without a rising edge before timeout is declared; must be at most 2^CNT_W-1.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: measurement enable; level-sensitive.
- sig_in, input, 1: asynchronous slow signal under measurement.
- period, output, CNT_W: clk cycles between the last two detected rising edges.
- high_time, output, CNT_W: clk cycles from a detected rise to the following detected fall, within the same published cycle.
- valid, output, 1: single-cycle strobe; period and high_time were updated this cycle.
- timeout, output, 1: sticky flag; no rising edge seen within TIMEOUT cycles.
- busy, output, 1: high while in the ARM or MEAS state.

Behaviour:
- Reset values: period=0, high_time=0, valid=0, timeout=0, busy=0. State=IDLE, counter=0, synchroniser flops=0.
- Synchroniser and edge detection:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - A level first sampled at clk edge k produces rise/fall at edge k+SYNC_STAGES, so total latency is SYNC_STAGES cycles.
- State machine (three states):
  - IDLE: busy=0, counter held at 0. en=1 moves to ARM.
  - ARM: wait for rise. On rise, counter<=1 and move to MEAS. No valid is issued, because the first edge only starts a measurement.
  - MEAS: counter increments every cycle.
    - On fall: hi_cap<=counter.
    - On rise: period<=counter, high_time<=hi_cap, valid<=1, counter<=1, timeout<=0. Stay in MEAS, so measurement is continuous and back-to-back.
    - If counter reaches TIMEOUT with no rise: timeout<=1 and move to ARM. period and high_time keep their last values; no valid.
- en deasserted in any state: move to IDLE on the next edge and abandon any partial measurement. valid=0 and no output update. timeout keeps its value until the next rst or the next successful measurement.
- Counting: for rises detected at edges a and a+P, period=P exactly.
  - A rise and a fall cannot occur in the same cycle, because they come from the same history flop.
  - If no fall occurred since the last rise, which is impossible for sig_in but holds after re-arming, high_time publishes 0.
- Counter arithmetic: unsigned, CNT_W bits. It never wraps, because timeout fires before 2^CNT_W-1.
- rst takes priority over en and over all edges. Mid-measurement it returns the block to the reset values on the next edge.
- valid is never high for two consecutive cycles, since the minimum detectable period is 2 cycles.

Decomposition:
- Shared package tick_meter_pkg:
  - state enum {IDLE, ARM, MEAS}.
  - constants SYS_CLK_HZ=100000000 and DEF_TIMEOUT=2*SYS_CLK_HZ.
- One sub-module, sync_edge_detect:
  - Contains the SYNC_STAGES synchroniser and history flop.
  - Outputs sync, rise and fall.
  - Is reusable for buttons and other asynchronous inputs.
- The parent holds the FSM, counter and output registers.

Test Plan:
- Square wave: TIMEOUT=50, en=1, sig_in toggles every 5 clk, synchronous to clk. After the first full cycle, expect valid every 10 clk with period=10, high_time=5, and timeout=0 throughout.
- Duty: sig_in high 3 clk, low 9 clk, repeating. Expect period=12, high_time=3. The first valid appears only after the second detected rise.
- Timeout: TIMEOUT=50, sig_in held low after one rise. Expect timeout=1 exactly 50 clk after that rise was detected, state ARM, period unchanged, no valid. A later restart of the 10-clk wave clears timeout on the first new valid.
- Enable drop: deassert en mid-period (counter=4). Expect busy=0 next cycle and no valid. Re-enable: the first rise arms and the second rise gives valid with period=10.
- Reset mid-operation: pulse rst for 1 clk while in MEAS. Expect all outputs 0 next cycle. Measurement restarts with en=1 and the next rise does not produce valid.
- Asynchronous jitter: sig_in edges offset randomly within a clk period, nominal period 10. Expect period within {9,10,11}, valid never high on consecutive cycles, and no X on any output.

Source files
------------

// File: rtl/tick_meter_pkg.sv
// Shared state encoding and clock constants for the tick period meter and
// anything else that has to agree with it on the system clock rate.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } meter_state_e;

    localparam int SYS_CLK_HZ  = 100000000;
    localparam int DEF_TIMEOUT = 2 * SYS_CLK_HZ;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser plus a history flop, giving a clean level and
// single-cycle rise/fall pulses for any asynchronous input.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              hist_q;
    logic              hist_d;

    // Shift toward the MSB; the MSB is the first flop considered metastability-safe.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], sig_i};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow asynchronous tick in system clock
// cycles, publishing one pair per input cycle with a valid strobe and a timeout flag.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             sig_in_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    logic sig_rise;
    logic sig_fall;
    logic sig_sync_unused;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (sig_in_i),
        .sync_o (sig_sync_unused),
        .rise_o (sig_rise),
        .fall_o (sig_fall)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dropping enable abandons whatever was in progress, from any state.
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARM;
                ARM:     if (sig_rise) state_d = MEAS;
                MEAS:    if (!sig_rise && (cnt_q == TIMEOUT_C)) state_d = ARM;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ARM) || (state_q == MEAS);
    end

    // A rise both closes the running measurement and opens the next one,
    // so the counter restarts at 1 rather than 0.
    always_comb begin
        cnt_d     = cnt_q;
        hi_cap_d  = hi_cap_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (!en_i) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                end
                ARM: begin
                    if (sig_rise) begin
                        cnt_d    = ONE_C;
                        hi_cap_d = '0;
                    end
                end
                MEAS: begin
                    if (sig_rise) begin
                        period_d  = cnt_q;
                        high_d    = hi_cap_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = ONE_C;
                        hi_cap_d  = '0;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + ONE_C;
                        if (sig_fall) begin
                            hi_cap_d = cnt_q;
                        end
                    end
                end
                default: begin
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            hi_cap_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_cap_q  <= hi_cap_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o    = period_q;
    assign high_time_o = high_q;
    assign valid_o     = valid_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Randomised scoreboard bench for tick_period_meter: a timeline model predicts
// each published measurement, and a negedge monitor compares every cycle.
module tb_tick_period_meter;

    localparam int CNT_W   = 32;
    localparam int STAGES  = 2;
    localparam int TO      = 50;
    localparam int MAXE    = 8000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             sigIn = 1'b0;
    logic [CNT_W-1:0] periodOut;
    logic [CNT_W-1:0] highOut;
    logic             validOut;
    logic             timeoutOut;
    logic             busyOut;

    int checks = 0;
    int failures = 0;

    tick_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (STAGES),
        .TIMEOUT     (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .sig_in_i    (sigIn),
        .period_o    (periodOut),
        .high_time_o (highOut),
        .valid_o     (validOut),
        .timeout_o   (timeoutOut),
        .busy_o      (busyOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int h;
    } meas_t;

    meas_t expQ[$];
    bit    sampledSig[MAXE];
    int    edgeNo = 0;
    int    lastResetEdge = -1;
    int    lastRise = -1;
    int    lastFall = -1;
    bit    prevActive = 0;
    bit    expTimeout = 0;
    bit    expBusy = 0;
    int    expPeriod = 0;
    int    expHigh = 0;
    bit    prevValid = 0;
    bit    jitterPhase = 0;
    int    wavePhase = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // The level the meter sees for the sample taken at edge j; a reset wipes
    // every sample up to and including the reset edge.
    function automatic bit effSig(input int j);
        if (j < 0 || j <= lastResetEdge || j >= MAXE) return 1'b0;
        return sampledSig[j];
    endfunction

    // Reference model: a measurement is the distance between successive
    // detected rises, each detected STAGES edges after its level is sampled.
    initial begin
        forever begin
            int  k;
            bit  riseNow;
            bit  fallNow;
            @(posedge clk);
            k = edgeNo;
            if (k < MAXE) sampledSig[k] = sigIn;
            riseNow = effSig(k - STAGES) && !effSig(k - STAGES - 1);
            fallNow = !effSig(k - STAGES) && effSig(k - STAGES - 1);
            if (rst) begin
                lastResetEdge = k;
                lastRise = -1;
                lastFall = -1;
                expTimeout = 0;
                expBusy = 0;
                expPeriod = 0;
                expHigh = 0;
                prevActive = 0;
                expQ.delete();
            end else if (!en) begin
                lastRise = -1;
                expBusy = 0;
                prevActive = 0;
            end else begin
                expBusy = 1;
                if (prevActive) begin
                    if (riseNow) begin
                        if (lastRise >= 0) begin
                            meas_t m;
                            m.p = k - lastRise;
                            m.h = (lastFall > lastRise) ? (lastFall - lastRise) : 0;
                            expQ.push_back(m);
                            expPeriod = m.p;
                            expHigh = m.h;
                            expTimeout = 0;
                        end
                        lastRise = k;
                    end else if (lastRise >= 0 && (k - lastRise) == TO) begin
                        expTimeout = 1;
                        lastRise = -1;
                    end else if (fallNow && lastRise >= 0) begin
                        lastFall = k;
                    end
                end
                prevActive = 1;
            end
            edgeNo++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (edgeNo > 0) begin
                checkOutput("x_on_outputs", 64'($isunknown({periodOut, highOut, validOut, timeoutOut, busyOut})), 0);
                checkOutput("valid_consecutive", 64'(validOut && prevValid), 0);
                checkOutput("valid_strobe", 64'(validOut), 64'(expQ.size() != 0));
                if (expQ.size() != 0) begin
                    meas_t m;
                    m = expQ.pop_front();
                    if (validOut) begin
                        checkOutput("valid_period", 64'(periodOut), 64'(m.p));
                        checkOutput("valid_high_time", 64'(highOut), 64'(m.h));
                    end
                end
                if (jitterPhase && validOut) begin
                    checkOutput("jitter_period_range", 64'(periodOut >= 9 && periodOut <= 11), 1);
                end
                checkOutput("timeout_flag", 64'(timeoutOut), 64'(expTimeout));
                checkOutput("busy", 64'(busyOut), 64'(expBusy));
                checkOutput("period_held", 64'(periodOut), 64'(expPeriod));
                checkOutput("high_time_held", 64'(highOut), 64'(expHigh));
                prevValid = validOut;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at time %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // One call per clock: inputs change a little after the rising edge so the
    // next edge is always the first to sample them.
    task automatic applyStimulus(input bit e, input bit r, input bit s, input int off);
        @(posedge clk);
        #(off);
        en = e;
        rst = r;
        sigIn = s;
    endtask

    task automatic runWave(input bit e, input bit r, input int cycles, input int hi, input int per);
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(e, r, (wavePhase % per) < hi, 1);
            wavePhase++;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 1);
        @(negedge clk);
        checkOutput("reset_period", 64'(periodOut), 0);
        checkOutput("reset_high_time", 64'(highOut), 0);
        checkOutput("reset_busy", 64'(busyOut), 0);

        wavePhase = 0;
        runWave(1, 0, 100, 5, 10);
        @(negedge clk);
        checkOutput("square_period", 64'(periodOut), 10);
        checkOutput("square_high_time", 64'(highOut), 5);
        checkOutput("square_timeout", 64'(timeoutOut), 0);

        wavePhase = 0;
        runWave(1, 0, 120, 3, 12);
        @(negedge clk);
        checkOutput("duty_period", 64'(periodOut), 12);
        checkOutput("duty_high_time", 64'(highOut), 3);

        for (int i = 0; i < 12; i++) applyStimulus(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 1);
        for (int i = 0; i < 70; i++) applyStimulus(1, 0, 0, 1);
        @(negedge clk);
        checkOutput("timeout_set", 64'(timeoutOut), 1);
        checkOutput("timeout_busy", 64'(busyOut), 1);
        checkOutput("timeout_period_kept", 64'(periodOut), 64'(expPeriod));

        wavePhase = 0;
        runWave(1, 0, 60, 5, 10);
        @(negedge clk);
        checkOutput("restart_timeout_clear", 64'(timeoutOut), 0);
        checkOutput("restart_period", 64'(periodOut), 10);

        runWave(1, 0, 24, 5, 10);
        runWave(0, 0, 6, 5, 10);
        runWave(1, 0, 60, 5, 10);
        @(negedge clk);
        checkOutput("reenable_period", 64'(periodOut), 10);

        runWave(1, 0, 27, 5, 10);
        runWave(1, 1, 1, 5, 10);
        runWave(1, 0, 1, 5, 10);
        @(negedge clk);
        checkOutput("midrst_period", 64'(periodOut), 0);
        checkOutput("midrst_valid", 64'(validOut), 0);
        checkOutput("midrst_busy", 64'(busyOut), 0);
        runWave(1, 0, 40, 5, 10);

        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);
        jitterPhase = 1;
        for (int p = 0; p < 25; p++) begin
            int s;
            int f;
            s = int'($urandom_range(0, 1));
            f = 5 + int'($urandom_range(0, 1));
            for (int c = 0; c < 10; c++) begin
                if (c == s) applyStimulus(1, 0, 1, int'($urandom_range(1, 9)));
                else if (c == f) applyStimulus(1, 0, 0, int'($urandom_range(1, 9)));
                else applyStimulus(1, 0, sigIn, 1);
            end
        end
        jitterPhase = 0;
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1);
        @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
